// File: rtl/tinyvga_pkg.sv
// Shared 640x480@60 timing constants, counter type and TinyVGA PMOD bit layout
// for the video timing generator.
package tinyvga_pkg;

   localparam int CNT_W   = 10;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef logic [CNT_W-1:0] cnt_t;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;

   function automatic int axis_total(input int visible, input int front,
                                     input int sync, input int back);
      return visible + front + sync + back;
   endfunction

   localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

   // uo_out layout {HS,B0,G0,R0,VS,B1,G1,R1}
   localparam int HS_BIT = 7;
   localparam int B0_BIT = 6;
   localparam int G0_BIT = 5;
   localparam int R0_BIT = 4;
   localparam int VS_BIT = 3;
   localparam int B1_BIT = 2;
   localparam int G1_BIT = 1;
   localparam int R1_BIT = 0;

endpackage

// File: rtl/vga_axis_counter.sv
// One video axis: a wrapping position counter with decodes for the visible
// region and the sync window. Used once for H and once for V.
module vga_axis_counter
   import tinyvga_pkg::*;
#(
   parameter int VISIBLE = H_VISIBLE,
   parameter int FRONT   = H_FRONT,
   parameter int SYNC    = H_SYNC,
   parameter int BACK    = H_BACK
) (
   input  logic clk,
   input  logic rst_n,
   input  logic step,
   output cnt_t cnt,
   output logic wrap,
   output logic in_sync,
   output logic in_visible
);

   localparam int   TOTAL      = axis_total(VISIBLE, FRONT, SYNC, BACK);
   localparam cnt_t LAST       = cnt_t'(TOTAL - 1);
   localparam cnt_t SYNC_FIRST = cnt_t'(VISIBLE + FRONT);
   localparam cnt_t SYNC_LAST  = cnt_t'(VISIBLE + FRONT + SYNC - 1);
   localparam cnt_t VIS_END    = cnt_t'(VISIBLE);

   if (TOTAL > CNT_MAX) begin : g_total_check
      $error("vga_axis_counter: axis total %0d does not fit the counter", TOTAL);
   end

   // wrap flags the terminal count, so the next axis can step on it
   assign wrap       = (cnt == LAST);
   assign in_sync    = (cnt >= SYNC_FIRST) && (cnt <= SYNC_LAST);
   assign in_visible = (cnt < VIS_END);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (step) begin
         cnt <= wrap ? '0 : cnt + cnt_t'(1);
      end
   end

endmodule

// File: rtl/tinyvga_out.sv
// 640x480 timing generator with a registered, blanked TinyVGA output byte.
// uo_out shows the pixel that x_o/y_o presented one enabled cycle earlier.
module tinyvga_out #(
   parameter int H_VISIBLE = tinyvga_pkg::H_VISIBLE,
   parameter int H_FRONT   = tinyvga_pkg::H_FRONT,
   parameter int H_SYNC    = tinyvga_pkg::H_SYNC,
   parameter int H_BACK    = tinyvga_pkg::H_BACK,
   parameter int V_VISIBLE = tinyvga_pkg::V_VISIBLE,
   parameter int V_FRONT   = tinyvga_pkg::V_FRONT,
   parameter int V_SYNC    = tinyvga_pkg::V_SYNC,
   parameter int V_BACK    = tinyvga_pkg::V_BACK,
   parameter bit SYNC_NEG  = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [5:0] rgb_i,
   output logic [9:0] x_o,
   output logic [9:0] y_o,
   output logic       active_o,
   output logic       line_start_o,
   output logic       frame_start_o,
   output logic [7:0] uo_out
);

   import tinyvga_pkg::*;

   localparam logic       SYNC_IDLE = SYNC_NEG ? 1'b1 : 1'b0;
   localparam logic [7:0] UO_IDLE   = (8'(SYNC_IDLE) << HS_BIT) | (8'(SYNC_IDLE) << VS_BIT);

   cnt_t       h_cnt;
   cnt_t       v_cnt;
   logic       h_wrap;
   logic       h_sync;
   logic       h_vis;
   logic       v_sync;
   logic       v_vis;
   logic       v_wrap_unused;
   logic [5:0] rgb_masked;
   logic [7:0] uo_next;

   vga_axis_counter #(
      .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
   ) u_h_axis (
      .clk       (clk),
      .rst_n     (rst_n),
      .step      (ena),
      .cnt       (h_cnt),
      .wrap      (h_wrap),
      .in_sync   (h_sync),
      .in_visible(h_vis)
   );

   vga_axis_counter #(
      .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
   ) u_v_axis (
      .clk       (clk),
      .rst_n     (rst_n),
      .step      (ena & h_wrap),
      .cnt       (v_cnt),
      .wrap      (v_wrap_unused),
      .in_sync   (v_sync),
      .in_visible(v_vis)
   );

   assign x_o           = h_cnt;
   assign y_o           = v_cnt;
   assign active_o      = h_vis & v_vis;
   assign line_start_o  = (h_cnt == '0);
   assign frame_start_o = line_start_o && (v_cnt == '0);
   assign rgb_masked    = rgb_i & {6{active_o}};

   // rgb_i is {R1,R0,G1,G0,B1,B0}; scatter it into the PMOD byte order
   always_comb begin
      uo_next         = '0;
      uo_next[HS_BIT] = h_sync ^ SYNC_IDLE;
      uo_next[VS_BIT] = v_sync ^ SYNC_IDLE;
      uo_next[R1_BIT] = rgb_masked[5];
      uo_next[R0_BIT] = rgb_masked[4];
      uo_next[G1_BIT] = rgb_masked[3];
      uo_next[G0_BIT] = rgb_masked[2];
      uo_next[B1_BIT] = rgb_masked[1];
      uo_next[B0_BIT] = rgb_masked[0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         uo_out <= UO_IDLE;
      end else if (ena) begin
         uo_out <= uo_next;
      end
   end

endmodule
